// File: rtl/video_compositor_n.sv
// N-layer line compositor: picks the top visible palette index per pixel
// and resolves it to a colour through a one-word cached VRAM palette.
// Ports: clk_i/rst_i, frame/line/pixel strobes, buff_addr_o column,
// layer_data_i/layer_enable_i, pal_base_i/pal_inval_i, VRAM strobe/ack
// read port, color_data_o/color_valid_o result, sticky underrun_o.
module video_compositor_n #(
  parameter int NUM_LAYERS = 4,
  parameter int COL_W      = 10,
  parameter int PIX_W      = 8,
  parameter int VRAM_AW    = 15,
  parameter int COLOR_W    = 16,
  localparam int PB_W      = VRAM_AW - (PIX_W - 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        next_frame_i,
  input  logic                        next_line_i,
  input  logic                        next_pixel_i,
  output logic [COL_W-1:0]            buff_addr_o,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_data_i,
  input  logic [NUM_LAYERS-1:0]       layer_enable_i,
  input  logic [PB_W-1:0]             pal_base_i,
  input  logic                        pal_inval_i,
  output logic [VRAM_AW-1:0]          vram_addr_o,
  output logic                        vram_strobe_o,
  input  logic                        vram_ack_i,
  input  logic [2*COLOR_W-1:0]        vram_data_i,
  output logic [COLOR_W-1:0]          color_data_o,
  output logic                        color_valid_o,
  output logic                        underrun_o
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 strobe_q, strobe_d;
  logic [VRAM_AW-1:0]   addr_q, addr_d;
  logic                 hi_q, hi_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 valid_q, valid_d;
  logic                 underrun_q, underrun_d;
  logic                 cvld_q, cvld_d;
  logic [VRAM_AW-1:0]   tag_q, tag_d;
  logic [2*COLOR_W-1:0] cdata_q, cdata_d;

  logic [PIX_W-1:0]     sel_idx;
  logic [VRAM_AW-1:0]   w_addr;
  logic                 hit;

  // Ascending scan: a later (higher) visible layer overrides lower ones.
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (layer_enable_i[k] &&
          layer_data_i[k*PIX_W +: PIX_W] != '0)
        sel_idx = layer_data_i[k*PIX_W +: PIX_W];
    end
  end

  assign w_addr = {pal_base_i, sel_idx[PIX_W-1:1]};
  assign hit    = cvld_q && (tag_q == w_addr);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    strobe_d   = strobe_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    color_d    = color_q;
    valid_d    = 1'b0;
    underrun_d = underrun_q;
    cvld_d     = cvld_q;
    tag_d      = tag_q;
    cdata_d    = cdata_q;
    if (next_frame_i || next_line_i) begin
      // Abandons any fetch; a late ack lands in IDLE and is ignored.
      state_d  = IDLE;
      col_d    = '0;
      strobe_d = 1'b0;
      if (next_frame_i) begin
        cvld_d     = 1'b0;
        underrun_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (next_pixel_i) begin
            if (hit) begin
              color_d = sel_idx[0] ? cdata_q[2*COLOR_W-1:COLOR_W]
                                   : cdata_q[COLOR_W-1:0];
              valid_d = 1'b1;
              col_d   = col_q + COL_W'(1);
            end else begin
              addr_d   = w_addr;
              hi_d     = sel_idx[0];
              strobe_d = 1'b1;
              state_d  = FETCH;
            end
          end
        end
        FETCH: begin
          if (next_pixel_i)
            underrun_d = 1'b1;
          if (vram_ack_i) begin
            strobe_d = 1'b0;
            tag_d    = addr_q;
            cdata_d  = vram_data_i;
            cvld_d   = 1'b1;
            color_d  = hi_q ? vram_data_i[2*COLOR_W-1:COLOR_W]
                            : vram_data_i[COLOR_W-1:0];
            valid_d  = 1'b1;
            col_d    = col_q + COL_W'(1);
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Applied last so it beats a same-cycle cache fill.
    if (pal_inval_i)
      cvld_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      col_q      <= '0;
      strobe_q   <= 1'b0;
      addr_q     <= '0;
      hi_q       <= 1'b0;
      color_q    <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      cvld_q     <= 1'b0;
      tag_q      <= '0;
      cdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      strobe_q   <= strobe_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      color_q    <= color_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      cvld_q     <= cvld_d;
      tag_q      <= tag_d;
      cdata_q    <= cdata_d;
    end
  end

  assign buff_addr_o   = col_q;
  assign vram_addr_o   = addr_q;
  assign vram_strobe_o = strobe_q;
  assign color_data_o  = color_q;
  assign color_valid_o = valid_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_video_compositor_n.sv
// Testbench for video_compositor_n: transaction-level model plus a
// per-cycle compare process; a COL_W=2 twin shares inputs for wrap checks.
module tb_video_compositor_n;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        next_frame_i = 1'b0;
  logic        next_line_i = 1'b0;
  logic        next_pixel_i = 1'b0;
  logic [31:0] layer_data_i = '0;
  logic [3:0]  layer_enable_i = '0;
  logic [7:0]  pal_base_i = 8'h05;
  logic        pal_inval_i = 1'b0;
  logic        vram_ack_i = 1'b0;
  logic [31:0] vram_data_i = '0;

  logic [9:0]  buff_addr_o;
  logic [14:0] vram_addr_o;
  logic        vram_strobe_o;
  logic [15:0] color_data_o;
  logic        color_valid_o;
  logic        underrun_o;

  logic [1:0]  buff2;
  logic [14:0] addr2;
  logic        strobe2;
  logic [15:0] color2;
  logic        valid2;
  logic        underrun2;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [9:0]  m_col;
  logic [15:0] m_color;
  logic        m_valid, m_strobe, m_underrun;
  logic [14:0] m_addr;
  logic        m_hi, m_fetch;
  logic        m_cv;
  logic [14:0] m_tag;
  logic [31:0] m_word;

  always #5 clk_i = ~clk_i;

  video_compositor_n dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .next_frame_i(next_frame_i), .next_line_i(next_line_i),
    .next_pixel_i(next_pixel_i), .buff_addr_o(buff_addr_o),
    .layer_data_i(layer_data_i), .layer_enable_i(layer_enable_i),
    .pal_base_i(pal_base_i), .pal_inval_i(pal_inval_i),
    .vram_addr_o(vram_addr_o), .vram_strobe_o(vram_strobe_o),
    .vram_ack_i(vram_ack_i), .vram_data_i(vram_data_i),
    .color_data_o(color_data_o), .color_valid_o(color_valid_o),
    .underrun_o(underrun_o)
  );

  video_compositor_n #(.COL_W(2)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i),
    .next_frame_i(next_frame_i), .next_line_i(next_line_i),
    .next_pixel_i(next_pixel_i), .buff_addr_o(buff2),
    .layer_data_i(layer_data_i), .layer_enable_i(layer_enable_i),
    .pal_base_i(pal_base_i), .pal_inval_i(pal_inval_i),
    .vram_addr_o(addr2), .vram_strobe_o(strobe2),
    .vram_ack_i(vram_ack_i), .vram_data_i(vram_data_i),
    .color_data_o(color2), .color_valid_o(valid2),
    .underrun_o(underrun2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick(input logic [31:0] l,
                                      input logic [3:0] e);
    for (int k = 3; k >= 0; k--)
      if (e[k] && l[k*8 +: 8] != 8'h00) return l[k*8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [15:0] half(input logic [31:0] w,
                                       input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("color", {16'h0, color_data_o}, {16'h0, m_color});
      chk("valid", {31'h0, color_valid_o}, {31'h0, m_valid});
      chk("strobe", {31'h0, vram_strobe_o}, {31'h0, m_strobe});
      chk("underrun", {31'h0, underrun_o}, {31'h0, m_underrun});
      chk("col", {22'h0, buff_addr_o}, {22'h0, m_col});
      chk("col2", {30'h0, buff2}, {30'h0, m_col[1:0]});
      if (m_strobe)
        chk("addr", {17'h0, vram_addr_o}, {17'h0, m_addr});
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    m_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_col = '0; m_color = '0; m_strobe = 1'b0; m_underrun = 1'b0;
    m_fetch = 1'b0; m_cv = 1'b0;
  endtask

  task automatic request(input logic [31:0] l, input logic [3:0] e);
    logic [7:0]  idx;
    logic [14:0] w;
    idx = pick(l, e);
    w = {pal_base_i, idx[7:1]};
    layer_data_i = l;
    layer_enable_i = e;
    next_pixel_i = 1'b1;
    tick();
    next_pixel_i = 1'b0;
    if (m_fetch) begin
      m_underrun = 1'b1;
    end else if (m_cv && m_tag == w) begin
      m_color = half(m_word, idx[0]);
      m_valid = 1'b1;
      m_col++;
    end else begin
      m_fetch = 1'b1;
      m_strobe = 1'b1;
      m_addr = w;
      m_hi = idx[0];
    end
  endtask

  task automatic ack(input logic [31:0] word, input logic inval);
    vram_ack_i = 1'b1;
    vram_data_i = word;
    pal_inval_i = inval;
    tick();
    vram_ack_i = 1'b0;
    pal_inval_i = 1'b0;
    if (m_fetch) begin
      m_fetch = 1'b0;
      m_strobe = 1'b0;
      m_color = half(word, m_hi);
      m_valid = 1'b1;
      m_col++;
      m_tag = m_addr;
      m_word = word;
      m_cv = !inval;
    end else if (inval) begin
      m_cv = 1'b0;
    end
  endtask

  task automatic inval();
    pal_inval_i = 1'b1;
    tick();
    pal_inval_i = 1'b0;
    m_cv = 1'b0;
  endtask

  task automatic line_pulse(input logic frame);
    next_frame_i = frame;
    next_line_i = !frame;
    tick();
    next_frame_i = 1'b0;
    next_line_i = 1'b0;
    m_col = '0;
    m_fetch = 1'b0;
    m_strobe = 1'b0;
    if (frame) begin
      m_cv = 1'b0;
      m_underrun = 1'b0;
    end
  endtask

  localparam logic [31:0] L_PRIO = 32'h0012_0005;
  localparam logic [31:0] L_13   = 32'h0013_0000;
  localparam logic [31:0] L_40   = 32'h0000_0040;

  initial begin
    logic [1:0] bw [6];
    logic [1:0] bw_exp [6];
    bw_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    m_valid = 1'b0; m_color = '0; m_addr = '0; m_hi = 1'b0;
    m_tag = '0; m_word = '0;
    tick();
    do_reset();
    chk_en = 1'b1;
    chk("rst_color", {16'h0, color_data_o}, 32'h0);
    chk("rst_strobe", {31'h0, vram_strobe_o}, 32'h0);
    chk("rst_col", {22'h0, buff_addr_o}, 32'h0);

    // Priority: layer 2 (0x12) beats layer 0 (0x05)
    request(L_PRIO, 4'hF);
    chk("prio_strobe", {31'h0, vram_strobe_o}, 32'h1);
    chk("prio_addr", {17'h0, vram_addr_o}, 32'h0000_0289);
    ack(32'hAAAA_5555, 1'b0);
    chk("prio_color", {16'h0, color_data_o}, 32'h5555);
    chk("prio_valid", {31'h0, color_valid_o}, 32'h1);
    chk("prio_col", {22'h0, buff_addr_o}, 32'h1);

    // Same word, odd index: 1-cycle hit
    request(L_13, 4'hF);
    chk("hit_strobe", {31'h0, vram_strobe_o}, 32'h0);
    chk("hit_color", {16'h0, color_data_o}, 32'hAAAA);
    chk("hit_valid", {31'h0, color_valid_o}, 32'h1);

    inval();
    request(L_13, 4'hF);
    chk("inval_miss", {31'h0, vram_strobe_o}, 32'h1);
    ack(32'h1234_5678, 1'b0);
    chk("inval_color", {16'h0, color_data_o}, 32'h1234);

    pal_base_i = 8'h06;
    request(L_13, 4'hF);
    chk("base_miss", {31'h0, vram_strobe_o}, 32'h1);
    chk("base_addr", {17'h0, vram_addr_o}, 32'h0000_0309);
    repeat (3) tick();
    ack(32'hBEEF_CAFE, 1'b0);
    chk("base_color", {16'h0, color_data_o}, 32'hBEEF);

    // Transparent/disabled -> background index 0
    request(32'h0, 4'hF);
    chk("bg_addr", {17'h0, vram_addr_o}, 32'h0000_0300);
    ack(32'h0000_7777, 1'b0);
    chk("bg_color", {16'h0, color_data_o}, 32'h7777);
    request(32'h0034_0000, 4'b1011);
    chk("dis_hit", {31'h0, vram_strobe_o}, 32'h0);
    chk("dis_color", {16'h0, color_data_o}, 32'h7777);

    // Underrun, line abort, ignored late ack, frame clear
    request(L_40, 4'hF);
    repeat (2) tick();
    request(L_40, 4'hF);
    chk("underrun", {31'h0, underrun_o}, 32'h1);
    line_pulse(1'b0);
    chk("abort_strobe", {31'h0, vram_strobe_o}, 32'h0);
    chk("abort_col", {22'h0, buff_addr_o}, 32'h0);
    ack(32'h5A5A_A5A5, 1'b0);
    chk("late_ack", {31'h0, color_valid_o}, 32'h0);
    chk("late_color", {16'h0, color_data_o}, 32'h7777);
    line_pulse(1'b1);
    chk("frame_clr", {31'h0, underrun_o}, 32'h0);

    // Invalidate coincident with ack wins
    request(L_40, 4'hF);
    ack(32'h1111_2222, 1'b1);
    chk("inv_ack_color", {16'h0, color_data_o}, 32'h2222);
    request(L_40, 4'hF);
    chk("inv_ack_miss", {31'h0, vram_strobe_o}, 32'h1);
    ack(32'h3333_4444, 1'b0);

    // Reset mid-fetch
    request(32'h0000_0042, 4'hF);
    chk("pre_rst_strobe", {31'h0, vram_strobe_o}, 32'h1);
    do_reset();
    chk("rst2_strobe", {31'h0, vram_strobe_o}, 32'h0);
    chk("rst2_color", {16'h0, color_data_o}, 32'h0);
    request(L_40, 4'hF);
    chk("rst2_miss", {31'h0, vram_strobe_o}, 32'h1);
    ack(32'h0000_9999, 1'b0);

    // Wrap on the COL_W=2 twin
    line_pulse(1'b1);
    bw[0] = buff2;
    request(L_40, 4'hF);
    ack(32'h0000_8888, 1'b0);
    bw[1] = buff2;
    for (int i = 2; i < 6; i++) begin
      request(L_40, 4'hF);
      bw[i] = buff2;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("wrap%0d", i), {30'h0, bw[i]}, {30'h0, bw_exp[i]});

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
